// File: rtl/subtractor_serial_nbit_if.sv
// Handshake/data bundle for subtractor_serial_nbit.
//   in_valid/in_ready/a/b          : operand pair handshake (master drives a, b, in_valid)
//   out_valid/out_ready/diff/borrow: result handshake (master drives out_ready)
//   busy                           : block is in SHIFT or DONE
// master modport: the surrounding logic / bench; slave modport: the subtractor.
interface subtractor_serial_nbit_if #(
    parameter int unsigned N = 10
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         borrow;
    logic         busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, busy
    );
endinterface

// File: rtl/subtractor_serial_nbit.sv
// Bit-serial unsigned N-bit subtractor: diff = a - b, one bit per clock, LSB first.
// Ports:
//   clk_i : clock, all state changes on its rising edge
//   rst_i : synchronous active-high reset
//   bus   : subtractor_serial_nbit_if.slave (operand handshake, result handshake, busy)
// Optional build macro SUB_SATURATE_EN: when the final borrow is 1, diff is forced to 0
// (borrow still reported as 1). Undefined: diff wraps modulo 2^N.
// An operation takes exactly N SHIFT cycles followed by one or more DONE cycles.
module subtractor_serial_nbit #(
    parameter int unsigned N = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    subtractor_serial_nbit_if.slave bus
);
    localparam int unsigned CntW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      a_q, a_d;
    logic [N-1:0]      b_q, b_d;
    logic [N-1:0]      sh_q, sh_d;
    logic [N-1:0]      diff_q, diff_d;
    logic              br_q, br_d;
    logic              borrow_q, borrow_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              bit_diff;
    logic              br_next;

    // Full-subtractor cell on the current LSBs.
    assign bit_diff = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sh_d     = sh_q;
        diff_d   = diff_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sh_d    = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                sh_d  = {bit_diff, sh_q[N-1:1]};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(N - 1)) begin
                    // Last bit: publish the result; outputs change only on this edge.
                    state_d  = StDone;
                    borrow_d = br_next;
`ifdef SUB_SATURATE_EN
                    diff_d   = br_next ? '0 : sh_d;
`else
                    diff_d   = sh_d;
`endif
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            diff_q   <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            diff_q   <= diff_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
endmodule

// File: tb/tb_subtractor_serial_nbit.sv
// Self-checking bench for subtractor_serial_nbit (N=10): table of directed vectors plus
// hand-written backpressure, mid-operation reset and back-to-back sequences.
module tb_subtractor_serial_nbit;
    localparam int unsigned N = 10;
`ifdef SUB_SATURATE_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    subtractor_serial_nbit_if #(.N(N)) sif ();

    subtractor_serial_nbit #(.N(N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned a;
        int unsigned b;
        int unsigned diff;
        bit          borrow;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation with out_ready high. lat = edges from accept edge to out_valid seen.
    task automatic run_op(input int unsigned a, input int unsigned b, output int lat,
                          output int unsigned d, output bit br, output bit busy_seen,
                          output bit rdy_after, output bit ov_after);
        int w;
        w = 0;
        while (!sif.in_ready && w < 40) begin
            tick();
            w++;
        end
        sif.out_ready = 1'b1;
        sif.in_valid  = 1'b1;
        sif.a         = N'(a);
        sif.b         = N'(b);
        tick();
        sif.in_valid = 1'b0;
        busy_seen    = sif.busy;
        lat          = 0;
        while (!sif.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        d  = sif.diff;
        br = sif.borrow;
        tick();
        rdy_after = sif.in_ready;
        ov_after  = sif.out_valid;
    endtask

    initial begin
        int          lat;
        int unsigned d;
        bit          br, bsy, rdy, ov;
        int          acc_cyc[3];
        int unsigned res[3];
        int          idx_in, idx_out;
        bit          acc;
        bit          ov_seen;

        vecs[0] = '{5, 3, 2, 0};
        vecs[1] = '{3, 5, Sat ? 0 : 1022, 1};
        vecs[2] = '{1023, 0, 1023, 0};
        vecs[3] = '{0, 1023, Sat ? 0 : 1, 1};
        vecs[4] = '{45, 45, 0, 0};
        vecs[5] = '{100, 20, 80, 0};
        vecs[6] = '{512, 513, Sat ? 0 : 1023, 1};

        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b0;
        sif.a         = '0;
        sif.b         = '0;
        rst           = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset in_ready", sif.in_ready, 1);
        check("reset out_valid", sif.out_valid, 0);
        check("reset diff", sif.diff, 0);
        check("reset borrow", sif.borrow, 0);
        check("reset busy", sif.busy, 0);

        // Counting the accept cycle as cycle 0, out_valid rises in cycle N+1: N edges later.
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, lat, d, br, bsy, rdy, ov);
            check($sformatf("vec%0d latency", i), lat, N);
            check($sformatf("vec%0d diff", i), d, vecs[i].diff);
            check($sformatf("vec%0d borrow", i), br, vecs[i].borrow);
            check($sformatf("vec%0d busy", i), bsy, 1);
            check($sformatf("vec%0d in_ready after", i), rdy, 1);
            check($sformatf("vec%0d out_valid after", i), ov, 0);
        end

        // Backpressure: 200-55=145 held for 5 cycles; a new in_valid is ignored meanwhile.
        sif.out_ready = 1'b0;
        sif.in_valid  = 1'b1;
        sif.a         = N'(200);
        sif.b         = N'(55);
        tick();
        sif.a = N'(7);
        sif.b = N'(9);
        lat   = 0;
        while (!sif.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("bp latency", lat, N);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp out_valid c%0d", k), sif.out_valid, 1);
            check($sformatf("bp diff c%0d", k), sif.diff, 145);
            check($sformatf("bp in_ready c%0d", k), sif.in_ready, 0);
        end
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;
        tick();
        check("bp release out_valid", sif.out_valid, 0);
        check("bp release in_ready", sif.in_ready, 1);
        check("bp diff held in idle", sif.diff, 145);
        tick();
        check("bp no stray accept", sif.busy, 0);

        // Reset during the 4th SHIFT cycle of 100-20.
        sif.in_valid = 1'b1;
        sif.a        = N'(100);
        sif.b        = N'(20);
        tick();
        sif.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst in_ready", sif.in_ready, 1);
        check("rst out_valid", sif.out_valid, 0);
        check("rst busy", sif.busy, 0);
        check("rst diff", sif.diff, 0);
        check("rst borrow", sif.borrow, 0);
        ov_seen = 1'b0;
        for (int k = 0; k < N + 4; k++) begin
            tick();
            if (sif.out_valid) ov_seen = 1'b1;
        end
        check("rst no out_valid", ov_seen, 0);
        run_op(100, 20, lat, d, br, bsy, rdy, ov);
        check("post-rst latency", lat, N);
        check("post-rst diff", d, 80);
        check("post-rst borrow", br, 0);

        // Back-to-back: in_valid held high across three operations.
        idx_in        = 0;
        idx_out       = 0;
        sif.out_ready = 1'b1;
        sif.a         = N'(vecs[0].a);
        sif.b         = N'(vecs[0].b);
        sif.in_valid  = 1'b1;
        for (int cyc = 0; cyc < 200 && idx_out < 3; cyc++) begin
            acc = sif.in_valid && sif.in_ready;
            tick();
            if (acc) begin
                acc_cyc[idx_in] = cyc;
                idx_in++;
                if (idx_in < 3) begin
                    sif.a = N'(vecs[idx_in].a);
                    sif.b = N'(vecs[idx_in].b);
                end else begin
                    sif.in_valid = 1'b0;
                end
            end
            if (sif.out_valid) begin
                res[idx_out] = sif.diff;
                idx_out++;
            end
        end
        sif.in_valid = 1'b0;
        check("b2b results seen", idx_out, 3);
        if (idx_out == 3) begin
            check("b2b spacing 0-1", acc_cyc[1] - acc_cyc[0], N + 2);
            check("b2b spacing 1-2", acc_cyc[2] - acc_cyc[1], N + 2);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("b2b result %0d", k), res[k], vecs[k].diff);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
